uart_rx_core: RTL and testbench

Serial receiver for the peripheral block's UART. Accepts the asynchronous `PC_Uart_rxd` line, recovers 8N1 frames by 16x oversampling, and presents each byte in a holding register with valid, framing-error and overrun status. It sits directly upstream of the peripheral's memory-mapped UART RX data/status registers and the UART receive interrupt source.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_baud_tick.sv | 30 +++
 rtl/uart_rx_core.sv | 162 ++++++++++++++++
 tb/tb_uart_rx_core.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types and constants.
// FSM encoding, oversample ratio and data width.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 7;
  localparam int DATA_W     = 8;

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running DIV prescaler.
// Emits a one-cycle tick at count DIV-1; sync clear.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset || clr)
      cnt <= '0;
    else if (tick)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 receiver, 16x oversampled.
// Holding register with valid, framing-error and overrun status.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  input  logic       rd_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam logic [3:0] SC_MID  = 4'(MID_SAMPLE);
  localparam logic [3:0] SC_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] BI_LAST = 3'(DATA_W - 1);

  uart_state_t state, state_n;

  logic              rx_m, rxs;
  logic              tick;
  logic              armed;
  logic [3:0]        sc, sc_n;
  logic [2:0]        bi, bi_n;
  logic [DATA_W-1:0] shreg, shreg_n;
  logic              start_go;
  logic              done_ok;
  logic              done_bad;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_m <= 1'b1;
      rxs  <= 1'b1;
    end else begin
      rx_m <= rxd;
      rxs  <= rx_m;
    end
  end

  uart_baud_tick #(
    .DIV (DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (start_go),
    .tick  (tick)
  );

  // A start is accepted only after the line was seen high,
  // so a break or an aborted frame cannot retrigger.
  always_ff @(posedge clk) begin
    if (reset)
      armed <= 1'b0;
    else if (rxs)
      armed <= 1'b1;
    else if (start_go || done_bad)
      armed <= 1'b0;
  end

  always_comb begin
    state_n  = state;
    sc_n     = sc;
    bi_n     = bi;
    shreg_n  = shreg;
    start_go = 1'b0;
    done_ok  = 1'b0;
    done_bad = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rxs && armed) begin
          state_n  = START;
          sc_n     = '0;
          start_go = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          if (sc == SC_MID) begin
            if (rxs) begin
              state_n = IDLE;
            end else begin
              state_n = DATA;
              sc_n    = '0;
              bi_n    = '0;
            end
          end else begin
            sc_n = sc + 4'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          sc_n = sc + 4'd1;
          if (sc == SC_LAST) begin
            shreg_n = {rxs, shreg[DATA_W-1:1]};
            bi_n    = bi + 3'd1;
            if (bi == BI_LAST)
              state_n = STOP;
          end
        end
      end
      STOP: begin
        if (tick) begin
          sc_n = sc + 4'd1;
          if (sc == SC_LAST) begin
            state_n  = IDLE;
            done_ok  = rxs;
            done_bad = !rxs;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sc    <= '0;
      bi    <= '0;
      shreg <= '0;
    end else begin
      state <= state_n;
      sc    <= sc_n;
      bi    <= bi_n;
      shreg <= shreg_n;
    end
  end

  // Completion beats a coincident read: new byte, no overrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= done_bad;
      if (done_ok) begin
        rx_data  <= shreg;
        rx_valid <= 1'b1;
        if (rd_ack)
          overrun <= 1'b0;
        else if (rx_valid)
          overrun <= 1'b1;
      end else if (rd_ack && rx_valid) begin
        rx_valid <= 1'b0;
        overrun  <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed frames at 64 clk/bit.
// Checks data, status flags and timing edges.
module tb_uart_rx_core;

  logic       clk;
  logic       reset;
  logic       rxd;
  logic       rd_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int ntests;
  int nfail;
  int fe_cnt;

  uart_rx_core #(
    .CLK_FREQ (6_400_000),
    .BAUD     (100_000)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rxd       (rxd),
    .rd_ack    (rd_ack),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk)
    if (frame_err) fe_cnt <= fe_cnt + 1;

  // Caller is 1 time unit after a posedge; returns likewise.
  task automatic send_frame(input logic [7:0] d, input logic stop);
    rxd = 1'b0;
    repeat (64) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      repeat (64) @(posedge clk);
      #1;
    end
    rxd = stop;
    repeat (64) @(posedge clk);
    #1;
    rxd = 1'b1;
  endtask

  task automatic pulse_ack();
    @(posedge clk);
    #1 rd_ack = 1'b1;
    @(posedge clk);
    #1 rd_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rxd = 1'b1;
    rd_ack = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    ntests++;
    if (rx_data !== 8'h00) begin
      nfail++;
      $display("FAIL reset_data got %h want 00", rx_data);
    end
    ntests++;
    if ({rx_valid, frame_err, overrun, busy} !== 4'b0000) begin
      nfail++;
      $display("FAIL reset_flags got %b want 0000",
               {rx_valid, frame_err, overrun, busy});
    end
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic test_frame();
    logic v_early, v_late;
    v_early = 1'b0;
    v_late = 1'b0;
    @(posedge clk);
    #1;
    fork
      send_frame(8'h2D, 1'b1);
      begin
        repeat (610) @(posedge clk);
        #1 v_early = rx_valid;
        @(posedge clk);
        #1 v_late = rx_valid;
      end
    join
    ntests++;
    if ({v_early, v_late} !== 2'b01) begin
      nfail++;
      $display("FAIL frame_latency got %b want 01", {v_early, v_late});
    end
    ntests++;
    if (rx_data !== 8'h2D || rx_valid !== 1'b1) begin
      nfail++;
      $display("FAIL frame_2d got %h/%b want 2d/1", rx_data, rx_valid);
    end
    ntests++;
    if (fe_cnt !== 0 || overrun !== 1'b0) begin
      nfail++;
      $display("FAIL frame_status got fe=%0d ov=%b want 0/0",
               fe_cnt, overrun);
    end
    pulse_ack();
    #1;
    ntests++;
    if (rx_valid !== 1'b0) begin
      nfail++;
      $display("FAIL ack_clear got %b want 0", rx_valid);
    end
  endtask

  task automatic test_glitch();
    logic b_mid;
    @(posedge clk);
    #1 rxd = 1'b0;
    repeat (8) @(posedge clk);
    #1 rxd = 1'b1;
    b_mid = busy;
    repeat (40) @(posedge clk);
    #1;
    ntests++;
    if ({b_mid, busy, rx_valid} !== 3'b100) begin
      nfail++;
      $display("FAIL glitch got busy_mid/busy/valid=%b want 100",
               {b_mid, busy, rx_valid});
    end
  endtask

  task automatic test_frame_err();
    logic f0, f1, f2;
    int fe0;
    fe0 = fe_cnt;
    f0 = 1'b0;
    f1 = 1'b0;
    f2 = 1'b0;
    @(posedge clk);
    #1;
    fork
      send_frame(8'hA5, 1'b0);
      begin
        repeat (610) @(posedge clk);
        #1 f0 = frame_err;
        @(posedge clk);
        #1 f1 = frame_err;
        @(posedge clk);
        #1 f2 = frame_err;
      end
    join
    ntests++;
    if ({f0, f1, f2} !== 3'b010 || fe_cnt - fe0 !== 1) begin
      nfail++;
      $display("FAIL frame_err_pulse got %b cnt=%0d want 010 cnt=1",
               {f0, f1, f2}, fe_cnt - fe0);
    end
    ntests++;
    if (rx_data !== 8'h2D || rx_valid !== 1'b0) begin
      nfail++;
      $display("FAIL frame_err_hold got %h/%b want 2d/0",
               rx_data, rx_valid);
    end
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    @(posedge clk);
    #1;
    send_frame(8'h11, 1'b1);
    ntests++;
    if (rx_data !== 8'h11 || overrun !== 1'b0) begin
      nfail++;
      $display("FAIL b2b_first got %h/%b want 11/0", rx_data, overrun);
    end
    send_frame(8'h22, 1'b1);
    ntests++;
    if ({rx_data, rx_valid, overrun} !== {8'h22, 2'b11}) begin
      nfail++;
      $display("FAIL b2b_overrun got %h/%b/%b want 22/1/1",
               rx_data, rx_valid, overrun);
    end
    pulse_ack();
    #1;
    ntests++;
    if ({rx_valid, overrun} !== 2'b00) begin
      nfail++;
      $display("FAIL b2b_ack got %b want 00", {rx_valid, overrun});
    end
  endtask

  task automatic test_ack_collide();
    @(posedge clk);
    #1;
    send_frame(8'h77, 1'b1);
    fork
      send_frame(8'h33, 1'b1);
      begin
        repeat (610) @(posedge clk);
        #1 rd_ack = 1'b1;
        @(posedge clk);
        #1 rd_ack = 1'b0;
      end
    join
    ntests++;
    if ({rx_data, rx_valid, overrun} !== {8'h33, 2'b10}) begin
      nfail++;
      $display("FAIL ack_collide got %h/%b/%b want 33/1/0",
               rx_data, rx_valid, overrun);
    end
  endtask

  task automatic test_break();
    int fe0;
    fe0 = fe_cnt;
    @(posedge clk);
    #1 rxd = 1'b0;
    repeat (2000) @(posedge clk);
    #1;
    ntests++;
    if (fe_cnt - fe0 !== 1 || busy !== 1'b0) begin
      nfail++;
      $display("FAIL break got fe=%0d busy=%b want 1/0",
               fe_cnt - fe0, busy);
    end
    rxd = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    send_frame(8'h96, 1'b1);
    ntests++;
    if (rx_data !== 8'h96 || fe_cnt - fe0 !== 1) begin
      nfail++;
      $display("FAIL break_recover got %h fe=%0d want 96/1",
               rx_data, fe_cnt - fe0);
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d;
    logic b_pre;
    d = 8'h5A;
    @(posedge clk);
    #1 rxd = 1'b0;
    repeat (64) @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      #1 rxd = d[i];
      repeat (64) @(posedge clk);
    end
    #1 b_pre = busy;
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    ntests++;
    if (b_pre !== 1'b1) begin
      nfail++;
      $display("FAIL midframe_busy got %b want 1", b_pre);
    end
    ntests++;
    if ({rx_data, rx_valid, frame_err, overrun, busy} !== 12'h000) begin
      nfail++;
      $display("FAIL midframe_reset got %h/%b want 00/0000", rx_data,
               {rx_valid, frame_err, overrun, busy});
    end
    rxd = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    send_frame(8'h3C, 1'b1);
    ntests++;
    if ({rx_data, rx_valid, overrun} !== {8'h3C, 2'b10}) begin
      nfail++;
      $display("FAIL midframe_next got %h/%b/%b want 3c/1/0",
               rx_data, rx_valid, overrun);
    end
  endtask

  initial begin
    ntests = 0;
    nfail = 0;
    fe_cnt = 0;
    test_reset();
    test_frame();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_ack_collide();
    pulse_ack();
    test_break();
    pulse_ack();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
